kme_apb_master: RTL and testbench
=================================

Name: kme_apb_master

Overview:
- APB initiator that drives the KME register-bus slave port (paddr/psel/penable/pwrite/pwdata in; prdata/pready/pslverr out).
- Converts single register commands, received on a valid/ready request channel, into APB3 transactions.
- Returns read data and error status on a valid/ready response channel.
- Sits between the bench/firmware-model register agent and the KME APB slave; one outstanding transaction at a time, with a wait-state timeout guard.

Parameters:
- ADDR_W, 20, APB address width (matches KME register-bus address bits).
- DATA_W, 32, APB read/write data width.
- TIMEOUT_CYCLES, 1024, max ACCESS-phase cycles before abort; 0 disables timeout.
- CNT_W, 16, width of wait counter and txn_count; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  block clock; APB and both channels are synchronous to it.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  request valid.
- cmd_ready  output  1  request accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  register address.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when high together with rsp_valid.
- rsp_rdata  output  DATA_W  read data; 0 for writes, timeouts and error reads.
- rsp_slverr  output  1  pslverr sampled at completion, or 1 on timeout.
- rsp_timeout  output  1  transaction aborted by the timeout.
- apb_paddr  output  ADDR_W  APB address.
- apb_psel  output  1  APB select.
- apb_penable  output  1  APB enable.
- apb_pwrite  output  1  APB direction.
- apb_pwdata  output  DATA_W  APB write data.
- apb_prdata  input  DATA_W  APB read data.
- apb_pready  input  1  APB ready.
- apb_pslverr  input  1  APB slave error.
- busy  output  1  high in any state other than IDLE.
- txn_count  output  CNT_W  completed-response counter; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered except cmd_ready and busy, which are decoded from state.
- Reset (rst high at a clk edge):
  - state = IDLE.
  - All APB outputs, rsp_* outputs and txn_count = 0.
  - cmd_ready = 1 from the first cycle after reset deassertion.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_addr/cmd_write/cmd_wdata into apb_paddr/apb_pwrite/apb_pwdata, go to SETUP.
  - apb_pwdata is loaded with 0 for reads.
- SETUP (exactly 1 cycle): psel = 1, penable = 0, go to ACCESS.
- ACCESS: psel = 1, penable = 1. apb_paddr, apb_pwrite and apb_pwdata are held stable from SETUP until the ACCESS phase completes.
  - pready = 1: capture prdata (read only; write → 0) and pslverr; rsp_timeout = 0; go to RESP.
  - On pslverr = 1 for a read, rsp_rdata = 0.
  - pready = 0: wait counter increments.
  - If TIMEOUT_CYCLES != 0 and wait count == TIMEOUT_CYCLES-1 with pready still 0: abort with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
  - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - Wait counter clears on entry to SETUP.
- RESP:
  - psel = penable = 0.
  - rsp_valid = 1, rsp_* held stable until rsp_ready.
  - On handshake: txn_count increments, rsp_valid deasserts next cycle, state returns to IDLE.
- Minimum latency (zero-wait slave, rsp_ready held high):
  - cmd accept cycle N; psel high at N+1; penable high at N+2; rsp_valid at N+3; next cmd_ready at N+4.
  - Throughput is one transaction per 4 cycles.
- No new command is accepted while busy. cmd_valid held high during a transaction is taken only on return to IDLE.
- pready is ignored outside ACCESS. pready together with timeout expiry in the same cycle counts as normal completion, not a timeout.
- Reset mid-transaction:
  - psel/penable drop at the reset edge.
  - The pending response is discarded and txn_count clears.
- txn_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then write addr 0x00104, data 0xDEADBEEF, zero-wait slave → psel at N+1, penable at N+2 with paddr = 0x00104, pwrite = 1, pwdata = 0xDEADBEEF; rsp_valid at N+3 with rdata = 0, slverr = 0; txn_count = 1.
- Read addr 0x00200, slave holds pready low 5 ACCESS cycles then returns 0x12345678 → paddr/pwrite stable for all 6 ACCESS cycles; rsp_rdata = 0x12345678, slverr = 0, timeout = 0.
- Read with pslverr = 1, prdata = 0xFFFFFFFF at pready → rsp_slverr = 1, rsp_rdata = 0, rsp_timeout = 0.
- TIMEOUT_CYCLES = 8, pready never asserted → exactly 8 cycles with penable = 1, then psel = 0; rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
- Back-to-back commands with rsp_ready low for 3 cycles → rsp_* stable for those cycles, cmd_ready = 0 throughout, second transaction's psel rises 2 cycles after the rsp handshake (IDLE accept, then SETUP).
- rst asserted during ACCESS → psel = penable = 0 and rsp_valid = 0 at the next edge, txn_count = 0, cmd_ready = 1 the cycle after rst deasserts.

Source files
------------

// File: rtl/kme_apb_master.sv
// APB3 initiator for the KME register bus: turns single valid/ready register
// commands into APB transactions and returns data/status on a response channel.
module kme_apb_master #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    txn_count_q, txn_count_d;
  logic [CNT_W-1:0]    wait_q, wait_d;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    txn_count_d   = txn_count_q;
    wait_d        = wait_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          psel_d   = 1'b1;
          wait_d   = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready wins over an expiring timeout in the same cycle
        if (apb_pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (!pwrite_q && !apb_pslverr) ? apb_prdata : '0;
          rsp_slverr_d  = apb_pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (TO_EN && (wait_q == TO_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      txn_count_q   <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      txn_count_q   <= txn_count_d;
      wait_q        <= wait_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign apb_paddr   = paddr_q;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign txn_count   = txn_count_q;

endmodule

// File: tb/tb_kme_apb_master.sv
// Directed bench for kme_apb_master: cycle-accurate APB slave stimulus and a
// response scoreboard; small TIMEOUT/CNT_W so timeout and counter wrap are reachable.
module tb_kme_apb_master;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int TO     = 8;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              slverr;
    logic              timeout;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr, rsp_timeout;
  logic [ADDR_W-1:0] apb_paddr;
  logic              apb_psel, apb_penable, apb_pwrite;
  logic [DATA_W-1:0] apb_pwdata, apb_prdata;
  logic              apb_pready, apb_pslverr;
  logic              busy;
  logic [CNT_W-1:0]  txn_count;

  int                checks = 0;
  int                errors = 0;
  logic [CNT_W-1:0]  exp_count = '0;
  exp_t              sb[$];

  always #5 clk = ~clk;

  kme_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .busy(busy), .txn_count(txn_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full command: drives the request, plays the APB slave, checks every
  // phase and retires the response against the scoreboard.
  task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input int waits, input logic [DATA_W-1:0] rd, input bit err,
                        input bit no_ready, input int hold, input bit chain);
    exp_t e, got;
    int   guard;
    int   acc;
    logic [DATA_W-1:0] pw_exp;
    e.timeout = no_ready;
    e.slverr  = err | no_ready;
    e.rdata   = (wr || err || no_ready) ? '0 : rd;
    sb.push_back(e);
    pw_exp = wr ? wd : '0;

    guard = 0;
    while (!cmd_ready && guard < 50) begin step(); guard++; end
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_write = ~wr;

    check("setup_psel", 64'(apb_psel), 64'(1));
    check("setup_penable", 64'(apb_penable), 64'(0));
    check("setup_paddr", 64'(apb_paddr), 64'(addr));
    check("setup_pwrite", 64'(apb_pwrite), 64'(wr));
    check("setup_pwdata", 64'(apb_pwdata), 64'(pw_exp));
    check("setup_cmd_ready", 64'(cmd_ready), 64'(0));
    check("setup_busy", 64'(busy), 64'(1));
    step();

    acc = 0;
    do begin
      check("acc_psel", 64'(apb_psel), 64'(1));
      check("acc_penable", 64'(apb_penable), 64'(1));
      check("acc_paddr", 64'(apb_paddr), 64'(addr));
      check("acc_pwrite", 64'(apb_pwrite), 64'(wr));
      check("acc_pwdata", 64'(apb_pwdata), 64'(pw_exp));
      acc++;
      if (!no_ready && acc > waits) begin
        apb_pready = 1'b1; apb_prdata = rd; apb_pslverr = err;
      end else begin
        apb_pready = 1'b0; apb_prdata = 32'hBAD0BAD0; apb_pslverr = 1'b1;
      end
      step();
    end while (apb_penable && acc < 40);
    apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = 32'hA5A5A5A5;
    check("access_cycles", 64'(acc), 64'(no_ready ? TO : waits + 1));

    check("resp_psel", 64'(apb_psel), 64'(0));
    check("resp_penable", 64'(apb_penable), 64'(0));
    check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
    got = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (chain) cmd_valid = 1'b1;
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'(got.rdata));
      check("hold_rsp_slverr", 64'(rsp_slverr), 64'(got.slverr));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      step();
    end
    rsp_ready = 1'b1;
    if (chain) cmd_valid = 1'b1;
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_rdata", 64'(rsp_rdata), 64'(got.rdata));
    check("rsp_slverr", 64'(rsp_slverr), 64'(got.slverr));
    check("rsp_timeout", 64'(rsp_timeout), 64'(got.timeout));
    check("rsp_busy", 64'(busy), 64'(1));
    step();
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check("post_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_txn_count", 64'(txn_count), 64'(exp_count));
    check("post_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; apb_prdata = '0; apb_pready = 1'b0; apb_pslverr = 1'b0;
    step(); step(); step();
    check("rst_psel", 64'(apb_psel), 64'(0));
    check("rst_penable", 64'(apb_penable), 64'(0));
    check("rst_paddr", 64'(apb_paddr), 64'(0));
    check("rst_pwdata", 64'(apb_pwdata), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_txn_count", 64'(txn_count), 64'(0));
    rst = 1'b0;
    step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));

    do_txn(1'b1, 20'h00104, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b0, 20'h00200, 32'h0, 5, 32'h12345678, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b0, 20'h00300, 32'h0, 0, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 1'b0);
    do_txn(1'b0, 20'h00400, 32'h0, 0, 32'h0, 1'b0, 1'b1, 0, 1'b0);
    // pready on the very last allowed ACCESS cycle is a normal completion
    do_txn(1'b0, 20'h00500, 32'h0, TO - 1, 32'hCAFEF00D, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b1, 20'h00600, 32'h11112222, 0, 32'h0, 1'b0, 1'b0, 3, 1'b1);
    do_txn(1'b0, 20'h00604, 32'h0, 1, 32'h55AA55AA, 1'b0, 1'b0, 0, 1'b0);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00700;
    step();
    cmd_valid = 1'b0;
    step();
    check("mid_penable", 64'(apb_penable), 64'(1));
    step();
    rst = 1'b1;
    step();
    check("mid_rst_psel", 64'(apb_psel), 64'(0));
    check("mid_rst_penable", 64'(apb_penable), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_txn_count", 64'(txn_count), 64'(0));
    rst = 1'b0;
    exp_count = '0;
    step();
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 17; i++)
      do_txn(1'b1, 20'(32'h00800 + 4 * i), 32'(i) * 32'h01010101, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    check("wrap_count", 64'(txn_count), 64'(1));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
